// File: rtl/ysyx_25060173_ctrl.sv
// Multi-cycle sequencing controller: fetches one instruction over the IFU
// handshake, decodes ADDI/AUIPC/EBREAK, drives the ALU and writes back.
module ysyx_25060173_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_pc,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        retire,
  output logic        halt,
  output logic        illegal
);

  // state  | meaning
  // RESET  | held in/just out of reset, outputs idle
  // FETCH  | fetch request issued at pc
  // WAIT   | waiting for instruction response
  // DECODE | classify latched instruction
  // EXEC   | drive ALU, capture result
  // WB     | register write, retire, pc += 4
  // HALT   | EBREAK reached, parked until reset
  // ERR    | unsupported instruction, parked until reset
  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]  state, state_nxt;
  logic [31:0] pc, inst, wb_data;
  logic        is_addi, is_auipc, is_ebreak;
  logic [31:0] imm_i, imm_u;

  assign is_addi   = (inst[6:0] == 7'b0010011) && (inst[14:12] == 3'b000);
  assign is_auipc  = (inst[6:0] == 7'b0010111);
  assign is_ebreak = (inst == 32'h0010_0073);
  assign imm_i     = {{20{inst[31]}}, inst[31:20]};
  assign imm_u     = {inst[31:12], 12'b0};

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  if (ifu_req_ready) state_nxt = S_WAIT;
      S_WAIT:   if (ifu_rsp_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_addi || is_auipc) state_nxt = S_EXEC;
        else if (is_ebreak)      state_nxt = S_HALT;
        else                     state_nxt = S_ERR;
      end
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RESET;
      pc      <= RESET_PC;
      inst    <= 32'd0;
      wb_data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && ifu_rsp_valid) inst <= ifu_rsp_inst;
      if (state == S_EXEC) wb_data <= alu_result;
      if (state == S_WB) pc <= pc + 32'd4;
    end
  end

  always_comb begin
    ifu_req_valid = (state == S_FETCH);
    ifu_pc        = pc;
    rf_raddr      = 5'd0;
    alu_src1      = 32'd0;
    alu_src2      = 32'd0;
    alu_op        = 2'b00;
    rf_wen        = 1'b0;
    rf_waddr      = 5'd0;
    rf_wdata      = 32'd0;
    retire        = 1'b0;
    halt          = (state == S_HALT);
    illegal       = (state == S_ERR);
    if (state == S_DECODE || state == S_EXEC) rf_raddr = inst[19:15];
    // Only ADDI or AUIPC can reach EXEC, so one opcode test selects the operands.
    if (state == S_EXEC) begin
      if (is_auipc) begin
        alu_src1 = pc;
        alu_src2 = imm_u;
        alu_op   = 2'b10;
      end else begin
        alu_src1 = rf_rdata;
        alu_src2 = imm_i;
        alu_op   = 2'b01;
      end
    end
    if (state == S_WB) begin
      rf_waddr = inst[11:7];
      rf_wdata = wb_data;
      rf_wen   = (inst[11:7] != 5'd0);
      retire   = 1'b1;
    end
  end

endmodule

// File: doc/ysyx_25060173_ctrl.md
# ysyx_25060173_ctrl

Multi-cycle sequencing controller for the single-cycle ALU (`alu_op` one-hot: bit0 = ADDI, bit1 = AUIPC) in the NPC core. It fetches one instruction at a time over a request/response handshake with the IFU, decodes ADDI/AUIPC/EBREAK, and drives the ALU operands and opcode. It then writes the result to the register file and advances the PC. It is the top-level control FSM between the IFU, the register file and the ALU.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC value loaded on reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ifu_req_valid` out 1: fetch request valid.
- `ifu_req_ready` in 1: IFU accepts the request.
- `ifu_pc` out 32: fetch address; always equals the current PC register.
- `ifu_rsp_valid` in 1: instruction response valid.
- `ifu_rsp_inst` in 32: instruction word.
- `rf_raddr` out 5: rs1 index, `inst[19:15]` of the latched instruction. The register file read is asynchronous.
- `rf_rdata` in 32: rs1 data.
- `alu_src1` out 32: ALU operand 1.
- `alu_src2` out 32: ALU operand 2.
- `alu_op` out 2: ALU opcode.
- `alu_result` in 32: ALU result (combinational).
- `rf_wen` out 1: register file write enable.
- `rf_waddr` out 5: rd index.
- `rf_wdata` out 32: write data.
- `retire` out 1: one-cycle pulse per completed instruction.
- `halt` out 1: sticky flag, EBREAK reached.
- `illegal` out 1: sticky flag, unsupported instruction.

## Operation
The FSM has states RESET, FETCH, WAIT, DECODE, EXEC, WB, HALT and ERR.

State transitions and per-state behaviour:
- **RESET:** all outputs 0 except `ifu_pc`, which is `RESET_PC`. Moves to FETCH on the first cycle with `rst`=0.
- **FETCH:** `ifu_req_valid`=1. Moves to WAIT when `ifu_req_ready`=1. `ifu_rsp_valid` is ignored in this state.
- **WAIT:** when `ifu_rsp_valid`=1, latch `ifu_rsp_inst` into the instruction register and move to DECODE. Stays in WAIT indefinitely otherwise.
- **DECODE:** classify the latched instruction:
  - ADDI (opcode `0010011`, funct3 `000`) → EXEC.
  - AUIPC (opcode `0010111`) → EXEC.
  - Exactly `32'h0010_0073` (EBREAK) → HALT.
  - Anything else → ERR.
- **EXEC:** drive the ALU, latch `alu_result` into the writeback register, then move to WB.
  - ADDI: `alu_src1`=`rf_rdata`, `alu_src2`=sign-extended `inst[31:20]`, `alu_op`=`2'b01`.
  - AUIPC: `alu_src1`=PC, `alu_src2`={`inst[31:12]`, 12'b0}, `alu_op`=`2'b10`.
- **WB:**
  - `rf_waddr`=`inst[11:7]` and `rf_wdata`=writeback register.
  - `rf_wen`=1 only if rd≠0.
  - `retire`=1, including when rd=0.
  - PC ← PC+4, modulo 2^32 (wraps).
  - Moves to FETCH.
- **HALT:** `halt`=1. No further requests are issued. Only `rst` exits this state.
- **ERR:** `illegal`=1. No further requests are issued. Only `rst` exits this state.

Output rules:
- Outside EXEC, `alu_op`=`2'b00` and `alu_src1`/`alu_src2`=0.
- Outside WB, `rf_wen`=0 and `retire`=0.
- `rf_raddr` is valid in DECODE and EXEC. It is 0 in RESET, FETCH and WAIT.

## Timing
- Outputs are decoded from the registered state and registers; there are no combinational paths from inputs to `ifu_req_valid`.
- Minimum latency is 5 cycles per instruction (FETCH, WAIT, DECODE, EXEC, WB), with `retire` in the 5th cycle. The next `ifu_req_valid` is asserted in the 6th cycle.
- Each IFU stall cycle (`ifu_req_ready`=0, or no response) adds one cycle. During a stall, `ifu_req_valid` and `ifu_pc` stay stable.
- The ALU result is sampled at the end of the EXEC cycle. The register file write happens at the end of the WB cycle.
- `halt` or `illegal` asserts in the cycle after DECODE and remains high until reset.
- Reset mid-operation: `rst`=1 in any state forces RESET at the next edge.
  - The instruction in flight is discarded, with no write and no retire.
  - PC returns to `RESET_PC`; the flags clear.
  - A response arriving while not in WAIT is dropped. The IFU must be reset together with this block.
- Reset values: state=RESET, PC=`RESET_PC`, instruction and writeback registers=0, all 1-bit outputs=0.

## Test plan
- **ADDI:** `ifu_rsp_inst`=`0x00500093` (addi x1,x0,5), `rf_rdata`=0, `ifu_req_ready` and response immediate → `alu_op`=01 in EXEC; in cycle 5 `rf_wen`=1, `rf_waddr`=1, `rf_wdata`=5, `retire`=1; next `ifu_pc`=`0x8000_0004`.
- **AUIPC and negative immediate:**
  - `0x12345117` at PC `0x8000_0000` → `alu_src1`=`0x8000_0000`, `alu_src2`=`0x1234_5000`, write x2=`0x9234_5000`.
  - `0xFFF08093` with `rf_rdata`=0 → write x1=`0xFFFF_FFFF`.
- **rd=x0 and stalls:** `0x00100013` with `ifu_req_ready` low for 3 cycles and response 2 cycles late → `rf_wen` stays 0, `retire` pulses once after 10 cycles, `ifu_pc` is stable throughout the stall.
- **EBREAK and illegal:**
  - `0x00100073` → `halt`=1 and no further `ifu_req_valid` for 20 cycles.
  - After reset, `0x00000000` → `illegal`=1 and `halt`=0.
- **PC wrap:** `RESET_PC`=`32'hFFFF_FFFC`, one ADDI retired → next `ifu_pc`=`0x0000_0000`.
- **Reset mid-operation:** `rst` asserted in EXEC → no `rf_wen` and no `retire`; after `rst` is deasserted, RESET lasts 1 cycle and then FETCH starts with `ifu_pc`=`RESET_PC`.
